dma_arbiter: RTL and testbench
==============================

Name: dma_arbiter

Overview:
- Shares the single dma_access request port between N DMA requesters: dma_zx plus upcoming SD/MP3 DMA engines.
- Selects one requester per transfer and muxes its address, direction and write data onto the shared port.
- Routes dma_ack immediately to the granted requester.
- Routes each dma_end back to the transfer's owner through an in-order owner FIFO, because dma_access can accept a new request before the previous one ends.

Parameters:
- N, 2, number of requesters (2..4); requester 0 is dma_zx.
- DEPTH, 2, maximum outstanding transfers (acked but not ended), power of 2.

Ports:
- clk  in  1  system clock (clk_fpga domain)
- rst_n  in  1  asynchronous active-low reset
- pri_fixed  in  1  0 = round-robin; 1 = fixed priority, lowest index wins
- req_en  in  N  per-requester enable mask; a disabled requester is never granted
- rq_req  in  N  request from requester i
- rq_addr  in  N*22  22-bit address of requester i, packed with i*22 as the LSB
- rq_rnw  in  N  1 = read, 0 = write
- rq_wd  in  N*8  write data of requester i
- rq_ack  out  N  one-cycle pulse: request i accepted by dma_access
- rq_end  out  N  one-cycle pulse: transfer of requester i complete
- rq_rd  out  8  read data, broadcast to all requesters; valid on the cycle of any rq_end
- dma_req  out  1  to dma_access
- dma_addr  out  22  to dma_access
- dma_rnw  out  1  to dma_access
- dma_wd  out  8  to dma_access
- dma_ack  in  1  from dma_access; pulse when the request is latched
- dma_end  in  1  from dma_access; pulse when the transfer is done, with dma_rd valid
- dma_rd  in  8  from dma_access
- busy  out  1  1 while any transfer is outstanding or dma_req is high
- err  out  1  sticky: dma_end arrived while the owner FIFO was empty

Behaviour:

Reset values (all async on rst_n low):
- dma_req = 0, rq_ack = 0, rq_end = 0, busy = 0, err = 0.
- Owner FIFO emptied; round-robin pointer = 0; lock cleared.

Candidate selection:
- Candidate set = rq_req & req_en.
- pri_fixed = 1: lowest-index candidate.
- pri_fixed = 0: first candidate at or after rr_ptr, scanning upward with wrap.

Lock register (lock, lock_id):
- Set when dma_req rises: lock = 1, lock_id = sel.
- While locked, sel = lock_id regardless of new or higher-priority requests, so address/data stay stable until acked.
- Cleared on dma_ack, or when rq_req[lock_id] drops before ack (request withdrawn, no ack issued).

Shared-port drive:
- dma_req = rq_req[sel] & req_en[sel] & !fifo_full.
- dma_addr, dma_rnw, dma_wd are combinational muxes of requester sel.
- When dma_req = 0, dma_addr, dma_rnw and dma_wd hold their last driven values (registered hold).

Ack handling:
- rq_ack[sel] = dma_ack, combinational, same cycle.
- On dma_ack: push sel into the owner FIFO; in round-robin mode rr_ptr <= sel+1 mod N.
- dma_ack while dma_req = 0 is ignored: no push, no rq_ack.

End handling:
- rq_end[head] = dma_end; rq_rd = dma_rd, pass-through.
- On dma_end: pop the FIFO.
- dma_end with FIFO empty: no rq_end pulse, err <= 1, sticky until reset.

Simultaneous events:
- dma_ack and dma_end in the same cycle: push and pop both occur; FIFO count unchanged.
- The ending owner is the old head, even when the FIFO held a single entry.

FIFO full:
- fifo_full (count == DEPTH) forces dma_req = 0 and lock is held.
- A pop in the same cycle does not unblock dma_req until the next cycle (registered count).

Request withdrawal and mask changes:
- Clearing req_en[lock_id] while locked drops dma_req and clears lock.
- Transfers already in the FIFO still complete and route normally.

Latency:
- Grant is zero-cycle: an idle requester's request appears on dma_req combinationally.
- Arbitration decision is re-evaluated every cycle the arbiter is unlocked.

busy = dma_req | (count != 0).

Test Plan:
- Single requester: rq_req[0] = 1, rq_addr0 = 22'h12345, rnw = 1; dma_ack at t+2, dma_end with dma_rd = 8'hA5 at t+6 → dma_addr = 12345 from t; rq_ack[0] at t+2; rq_end[0] with rq_rd = A5 at t+6; busy low at t+7.
- Round-robin contention: rq_req = 2'b11 held, every request acked after 1 cycle → grant order 0,1,0,1; dma_addr alternates between addr0 and addr1; each rq_end reaches its own owner.
- Fixed priority with lock: pri_fixed = 1, requester 1 granted and not yet acked, then rq_req[0] rises → dma_addr stays addr1 until dma_ack; the next grant goes to 0.
- Pipelined overlap, DEPTH = 2: acks for req0 then req1 with no end → dma_req forced low while full; then dma_end twice → rq_end[0] first, then rq_end[1]. Also check simultaneous ack + end keeps the count.
- Spurious end: dma_end with the FIFO empty → no rq_end; err = 1 and stays 1 until rst_n low.
- Reset mid-transfer: assert rst_n low with 1 outstanding → all outputs 0 immediately; after release, a late dma_end sets err without pulsing any rq_end.

Source files
------------

// File: rtl/dma_arbiter.sv
// Shares the single dma_access request port between N DMA requesters.
// Ack is routed to the current grantee; each end is routed to its owner through an in-order FIFO.
module dma_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pri_fixed,
    input  logic [N-1:0]    req_en,
    input  logic [N-1:0]    rq_req,
    input  logic [N*22-1:0] rq_addr,
    input  logic [N-1:0]    rq_rnw,
    input  logic [N*8-1:0]  rq_wd,
    output logic [N-1:0]    rq_ack,
    output logic [N-1:0]    rq_end,
    output logic [7:0]      rq_rd,
    output logic            dma_req,
    output logic [21:0]     dma_addr,
    output logic            dma_rnw,
    output logic [7:0]      dma_wd,
    input  logic            dma_ack,
    input  logic            dma_end,
    input  logic [7:0]      dma_rd,
    output logic            busy,
    output logic            err
);

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [N-1:0]    cand;
    logic [IW-1:0]   cand_sel;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   rr_ptr_q;
    logic            lock_q, lock_d;
    logic [IW-1:0]   lock_id_q, lock_id_d;
    logic            fifo_full;
    logic            accept;
    logic            pop;
    logic [IW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [IW-1:0]   head;
    logic [AW-1:0]   sel_addr;
    logic            sel_rnw;
    logic [DW-1:0]   sel_wd;
    logic [AW-1:0]   addr_q;
    logic            rnw_q;
    logic [DW-1:0]   wd_q;
    logic            err_q;

    assign cand = rq_req & req_en;

    // Fixed: lowest index wins. Round-robin: first candidate at or after rr_ptr, with wrap.
    always_comb begin
        cand_sel = '0;
        if (pri_fixed) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (cand[i]) cand_sel = IW'(i);
            end
        end else begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                if (cand[(int'(rr_ptr_q) + k) % int'(N)])
                    cand_sel = IW'((int'(rr_ptr_q) + k) % int'(N));
            end
        end
    end

    // Lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Lock next state: hold the grantee until acked or its request/enable drops
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (lock_q) begin
            if (accept || !rq_req[lock_id_q] || !req_en[lock_id_q])
                lock_d = 1'b0;
        end else if (dma_req && !dma_ack) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end
    end

    // Lock outputs: selected requester
    always_comb begin
        sel = cand_sel;
        if (lock_q) sel = lock_id_q;
    end

    assign fifo_full = (count_q == CW'(DEPTH));
    assign dma_req   = rst_n & rq_req[sel] & req_en[sel] & ~fifo_full;
    assign accept    = dma_req & dma_ack;
    assign pop       = dma_end & (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    assign sel_addr = rq_addr[32'(sel) * AW +: AW];
    assign sel_rnw  = rq_rnw[sel];
    assign sel_wd   = rq_wd[32'(sel) * DW +: DW];

    assign dma_addr = dma_req ? sel_addr : addr_q;
    assign dma_rnw  = dma_req ? sel_rnw  : rnw_q;
    assign dma_wd   = dma_req ? sel_wd   : wd_q;

    assign rq_ack = accept ? (N'(1) << sel) : '0;
    assign rq_end = pop ? (N'(1) << head) : '0;
    assign rq_rd  = dma_rd;
    assign busy   = dma_req | (count_q != '0);
    assign err    = err_q;

    // Last driven address/direction/data, shown while dma_req is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rnw_q  <= 1'b0;
            wd_q   <= '0;
        end else if (dma_req) begin
            addr_q <= sel_addr;
            rnw_q  <= sel_rnw;
            wd_q   <= sel_wd;
        end
    end

    // Round-robin pointer moves past each accepted requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (accept && !pri_fixed) begin
            rr_ptr_q <= (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
        end
    end

    // Owner FIFO: push on accepted ack, pop on a routed end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= sel;
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error: end with no outstanding owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (dma_end && count_q == '0) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed and pseudo-random bench for dma_arbiter; a queue-based model is checked every cycle,
// with hand-computed literal expectations at the key points of each scenario.
module tb_dma_arbiter;

    localparam int N     = 2;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pri_fixed;
    logic [N-1:0]    req_en;
    logic [N-1:0]    rq_req;
    logic [N*22-1:0] rq_addr;
    logic [N-1:0]    rq_rnw;
    logic [N*8-1:0]  rq_wd;
    logic [N-1:0]    rq_ack;
    logic [N-1:0]    rq_end;
    logic [7:0]      rq_rd;
    logic            dma_req;
    logic [21:0]     dma_addr;
    logic            dma_rnw;
    logic [7:0]      dma_wd;
    logic            dma_ack;
    logic            dma_end;
    logic [7:0]      dma_rd;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    dma_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pri_fixed(pri_fixed), .req_en(req_en),
        .rq_req(rq_req), .rq_addr(rq_addr), .rq_rnw(rq_rnw), .rq_wd(rq_wd),
        .rq_ack(rq_ack), .rq_end(rq_end), .rq_rd(rq_rd),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rnw(dma_rnw), .dma_wd(dma_wd),
        .dma_ack(dma_ack), .dma_end(dma_end), .dma_rd(dma_rd),
        .busy(busy), .err(err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: outstanding owners in order, current grantee (if held), rr pointer, sticky error, last port values
    int          owners[$];
    bit          m_lock;
    int          m_gid;
    int          m_ptr;
    bit          m_err;
    logic [21:0] m_addr;
    logic        m_rnw;
    logic [7:0]  m_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owners.delete();
        m_lock = 0; m_gid = 0; m_ptr = 0; m_err = 0;
        m_addr = '0; m_rnw = 1'b0; m_wd = '0;
    endtask

    // Check all outputs against the model for this cycle, then advance the model
    task automatic model_step();
        bit [N-1:0]  c;
        bit [N-1:0]  eack;
        bit [N-1:0]  eend;
        int          g;
        bit          r;
        logic [21:0] ea;
        logic        er;
        logic [7:0]  ew;
        if (!rst_n) begin
            chk("rst_dma_req", dma_req, 0);
            chk("rst_rq_ack", rq_ack, 0);
            chk("rst_rq_end", rq_end, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err, 0);
            chk("rst_dma_addr", dma_addr, 0);
            model_reset();
            return;
        end
        c = rq_req & req_en;
        g = -1;
        if (m_lock) g = m_gid;
        else if (pri_fixed) begin
            for (int i = 0; i < N; i++) if (c[i] && g < 0) g = i;
        end else begin
            for (int k = 0; k < N; k++) if (c[(m_ptr + k) % N] && g < 0) g = (m_ptr + k) % N;
        end
        r  = (g >= 0) && c[g] && (owners.size() < DEPTH);
        ea = r ? rq_addr[g*22 +: 22] : m_addr;
        er = r ? rq_rnw[g] : m_rnw;
        ew = r ? rq_wd[g*8 +: 8] : m_wd;
        eack = '0;
        if (r && dma_ack) eack[g] = 1'b1;
        eend = '0;
        if (dma_end && owners.size() > 0) eend[owners[0]] = 1'b1;
        chk("m_dma_req", dma_req, r);
        chk("m_dma_addr", dma_addr, ea);
        chk("m_dma_rnw", dma_rnw, er);
        chk("m_dma_wd", dma_wd, ew);
        chk("m_rq_ack", rq_ack, eack);
        chk("m_rq_end", rq_end, eend);
        chk("m_busy", busy, r || owners.size() > 0);
        chk("m_err", err, m_err);
        if (dma_end) chk("m_rq_rd", rq_rd, dma_rd);
        if (r) begin m_addr = ea; m_rnw = er; m_wd = ew; end
        if (dma_end) begin
            if (owners.size() > 0) void'(owners.pop_front());
            else m_err = 1;
        end
        if (r && dma_ack) begin
            owners.push_back(g);
            m_lock = 0;
            if (!pri_fixed) m_ptr = (g + 1) % N;
        end else if (m_lock && !c[m_gid]) begin
            m_lock = 0;
        end else if (r && !m_lock) begin
            m_lock = 1;
            m_gid  = g;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_step();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        at_neg();
        to_pos();
    endtask

    task automatic set_in(input logic [N-1:0] rq, input logic ack, input logic en, input logic [7:0] rd);
        rq_req  = rq;
        dma_ack = ack;
        dma_end = en;
        dma_rd  = rd;
    endtask

    task automatic do_reset();
        set_in(2'b00, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    localparam logic [21:0] A0 = 22'h00AAA;
    localparam logic [21:0] A1 = 22'h15555;

    initial begin
        rst_n = 1'b0; pri_fixed = 1'b0; req_en = 2'b11;
        rq_req = '0; rq_addr = '0; rq_rnw = '0; rq_wd = '0;
        dma_ack = 1'b0; dma_end = 1'b0; dma_rd = '0;
        model_reset();
        cyc();
        rst_n = 1'b1;

        // Single requester
        rq_addr[21:0] = 22'h12345; rq_rnw = 2'b01; rq_wd = {8'h5A, 8'h3C};
        set_in(2'b01, 0, 0, 8'h00); at_neg();
        chk("s1_addr_t0", dma_addr, 22'h12345); chk("s1_req_t0", dma_req, 1); to_pos();
        cyc();
        set_in(2'b01, 1, 0, 8'h00); at_neg(); chk("s1_ack_t2", rq_ack, 2'b01); to_pos();
        set_in(2'b00, 0, 0, 8'h00); cyc(); cyc(); cyc();
        set_in(2'b00, 0, 1, 8'hA5); at_neg();
        chk("s1_end_t6", rq_end, 2'b01); chk("s1_rd_t6", rq_rd, 8'hA5); to_pos();
        set_in(2'b00, 0, 0, 8'h00); at_neg(); chk("s1_busy_t7", busy, 0); to_pos();

        // Round-robin contention, ack one cycle after grant
        do_reset();
        rq_addr = {A1, A0}; rq_rnw = 2'b10;
        set_in(2'b11, 0, 0, 8'h00); at_neg(); chk("s2_addr_g0", dma_addr, A0); to_pos();
        set_in(2'b11, 1, 0, 8'h00); at_neg(); chk("s2_ack_0", rq_ack, 2'b01); to_pos();
        set_in(2'b11, 0, 0, 8'h00); at_neg(); chk("s2_addr_g1", dma_addr, A1); to_pos();
        set_in(2'b11, 1, 1, 8'h11); at_neg();
        chk("s2_ack_1", rq_ack, 2'b10); chk("s2_end_0", rq_end, 2'b01); to_pos();
        set_in(2'b11, 0, 0, 8'h00); at_neg(); chk("s2_addr_g2", dma_addr, A0); to_pos();
        set_in(2'b11, 1, 1, 8'h22); at_neg();
        chk("s2_ack_2", rq_ack, 2'b01); chk("s2_end_1", rq_end, 2'b10); to_pos();
        set_in(2'b11, 0, 0, 8'h00); at_neg(); chk("s2_addr_g3", dma_addr, A1); to_pos();
        set_in(2'b11, 1, 1, 8'h33); at_neg();
        chk("s2_ack_3", rq_ack, 2'b10); chk("s2_end_2", rq_end, 2'b01); to_pos();
        set_in(2'b00, 0, 1, 8'h44); at_neg(); chk("s2_end_3", rq_end, 2'b10); to_pos();
        set_in(2'b00, 0, 0, 8'h00); at_neg(); chk("s2_idle_busy", busy, 0); to_pos();

        // Fixed priority: a locked grant to 1 is not pre-empted by 0
        pri_fixed = 1'b1;
        set_in(2'b10, 0, 0, 8'h00); at_neg(); chk("s3_addr_1", dma_addr, A1); to_pos();
        set_in(2'b11, 0, 0, 8'h00); at_neg(); chk("s3_lock_addr", dma_addr, A1); to_pos();
        set_in(2'b11, 1, 0, 8'h00); at_neg(); chk("s3_ack_1", rq_ack, 2'b10); to_pos();
        set_in(2'b11, 0, 0, 8'h00); at_neg(); chk("s3_next_addr0", dma_addr, A0); to_pos();
        set_in(2'b01, 1, 0, 8'h00); at_neg(); chk("s3_ack_0", rq_ack, 2'b01); to_pos();
        set_in(2'b00, 0, 1, 8'h55); at_neg(); chk("s3_end_1", rq_end, 2'b10); to_pos();
        set_in(2'b00, 0, 1, 8'h66); at_neg(); chk("s3_end_0", rq_end, 2'b01); to_pos();
        pri_fixed = 1'b0;

        // Pipelined overlap up to DEPTH, full blocks dma_req until the cycle after a pop
        set_in(2'b01, 1, 0, 8'h00); at_neg(); chk("s4_ack_0", rq_ack, 2'b01); to_pos();
        set_in(2'b10, 1, 0, 8'h00); at_neg(); chk("s4_ack_1", rq_ack, 2'b10); to_pos();
        set_in(2'b01, 0, 0, 8'h00); at_neg();
        chk("s4_full_req", dma_req, 0); chk("s4_full_busy", busy, 1); to_pos();
        set_in(2'b01, 0, 1, 8'h77); at_neg();
        chk("s4_end_0", rq_end, 2'b01); chk("s4_pop_req", dma_req, 0); to_pos();
        set_in(2'b01, 0, 1, 8'h88); at_neg();
        chk("s4_unblk_req", dma_req, 1); chk("s4_end_1", rq_end, 2'b10); to_pos();
        set_in(2'b01, 1, 0, 8'h00); at_neg(); chk("s4_ack_0b", rq_ack, 2'b01); to_pos();
        set_in(2'b00, 0, 0, 8'h00); cyc();
        set_in(2'b00, 0, 1, 8'h99); at_neg(); chk("s4_end_0b", rq_end, 2'b01); to_pos();

        // Mask change while locked drops the request
        set_in(2'b01, 0, 0, 8'h00); at_neg(); chk("s4_mask_req", dma_req, 1); to_pos();
        req_en = 2'b10; at_neg(); chk("s4_mask_drop", dma_req, 0); to_pos();
        req_en = 2'b11; set_in(2'b10, 0, 0, 8'h00); at_neg(); chk("s4_mask_addr1", dma_addr, A1); to_pos();
        set_in(2'b10, 1, 0, 8'h00); at_neg(); chk("s4_mask_ack1", rq_ack, 2'b10); to_pos();
        set_in(2'b00, 0, 1, 8'h12); at_neg(); chk("s4_mask_end1", rq_end, 2'b10); to_pos();

        // Spurious end
        set_in(2'b00, 0, 1, 8'hAB); at_neg();
        chk("s5_no_end", rq_end, 2'b00); chk("s5_err_pre", err, 0); to_pos();
        set_in(2'b00, 0, 0, 8'h00); at_neg(); chk("s5_err_set", err, 1); to_pos();
        cyc(); cyc(); cyc();
        at_neg(); chk("s5_err_sticky", err, 1); to_pos();

        // Reset with one transfer outstanding, then a late end
        do_reset();
        set_in(2'b01, 1, 0, 8'h00); at_neg(); chk("s6_ack", rq_ack, 2'b01); to_pos();
        set_in(2'b00, 0, 0, 8'h00); at_neg(); chk("s6_busy", busy, 1); to_pos();
        set_in(2'b01, 1, 0, 8'h00); rst_n = 1'b0; at_neg();
        chk("s6_rst_req", dma_req, 0); chk("s6_rst_busy", busy, 0); chk("s6_rst_ack", rq_ack, 0); to_pos();
        rst_n = 1'b1;
        set_in(2'b00, 0, 1, 8'hCD); at_neg(); chk("s6_late_end", rq_end, 2'b00); to_pos();
        set_in(2'b00, 0, 0, 8'h00); at_neg(); chk("s6_late_err", err, 1); to_pos();

        // Pseudo-random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rq_req  = N'($urandom_range(0, 3));
            req_en  = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
            dma_ack = ($urandom_range(0, 2) == 0);
            dma_end = ($urandom_range(0, 3) == 0);
            dma_rd  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rq_addr = {22'($urandom), 22'($urandom)};
            if ($urandom_range(0, 3) == 0) rq_wd = 16'($urandom);
            rq_rnw = N'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) pri_fixed = ~pri_fixed;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
